pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NUM_STAGES, 4, number of pipeline registers; index 0 is fetch and NUM_STAGES-1 is commit.
REQ-002 Parameter ADDR_W, 30, word-address width.
REQ-003 Parameter IRQ_W, 8, interrupt request lines.
REQ-004 Parameter EXP_W, 3, exception code width; code 0 means no exception.
REQ-005 Parameter HAZ_STAGE, 1, stage stalled by a load hazard; legal range 0..NUM_STAGES-2.
REQ-006 Parameter EXC_VEC, 0x100, exception/interrupt handler word address.
REQ-007 clk  in  1  sole clock; all state updates on the rising edge.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 stage_busy  in  NUM_STAGES  per-stage busy.
REQ-010 ld_hazard  in  1  load-use hazard detected in stage HAZ_STAGE.
REQ-011 irq  in  IRQ_W  level-sensitive interrupt requests.
REQ-012 commit_en  in  1  valid instruction in the commit stage.
REQ-013 commit_pc  in  ADDR_W  commit-stage PC.
REQ-014 commit_exp  in  EXP_W  commit-stage exception code.
REQ-015 commit_eret  in  1  commit-stage instruction is ERET.
REQ-016 ie_we, ie_wdata  in  1, 1  interrupt-enable write.
REQ-017 mask_we, mask_wdata  in  1, IRQ_W  interrupt-mask write.
REQ-018 stall, flush  out  NUM_STAGES, NUM_STAGES  per-stage hold / bubble-insert.
REQ-019 redirect, new_pc  out  1, ADDR_W  PC redirect strobe and target.
REQ-020 epc, exp_code, exe_mode, ie, mask, int_detect  out  ADDR_W, EXP_W, 1, 1, IRQ_W, 1  architectural control state and pending-interrupt indication.

Function
REQ-021 stall[i] SHALL be combinational: OR of stage_busy[j] for j>=i, OR'd with ld_hazard for i<=HAZ_STAGE.
REQ-022 flush[i+1] SHALL be 1 when stall[i]=1 and stall[i+1]=0, inserting a bubble below the stall boundary.
REQ-023 A commit event SHALL be acted on only when commit_en=1 and stall[NUM_STAGES-1]=0; otherwise it is held until the busy condition clears.
REQ-024 int_detect SHALL equal ie & |(irq & ~mask) & (state==RUN).
REQ-025 Event priority at commit: exception (commit_exp!=0) > interrupt > ERET; a losing interrupt stays pending because it is level-sensitive.
REQ-026 Exception handling: epc<=commit_pc, exp_code<=commit_exp, saved_mode<=exe_mode, saved_ie<=ie, exe_mode<=0, ie<=0, target EXC_VEC.
REQ-027 Interrupt handling: same as REQ-026 except epc<=commit_pc+1 (mod 2^ADDR_W) and exp_code<=0.
REQ-028 ERET handling: exe_mode<=saved_mode, ie<=saved_ie, target=epc value before the edge.
REQ-029 The FSM SHALL have states RUN and REDIR; an acted event moves RUN->REDIR; REDIR->RUN unconditionally after one cycle.
REQ-030 In REDIR the block SHALL drive redirect=1, new_pc=latched target, flush all stages=1 and stall all stages=0, and SHALL ignore commit events and interrupts.
REQ-031 In RUN, redirect SHALL be 0 and new_pc SHALL hold its last value.
REQ-032 ie_we SHALL take effect on the next edge unless an event updates ie on the same edge; the event wins.

Reset
REQ-033 With rst=0, the block SHALL asynchronously set state=RUN, redirect=0, new_pc=0, epc=0, exp_code=0, exe_mode=0, ie=0, saved_mode=0, saved_ie=0.
REQ-034 Reset asserted mid-REDIR SHALL abort the redirect; redirect=0 on the first clock after release.

Configuration
REQ-035 Macro PIPE_CTRL_IRQ_MASK_EN.
- Defined: mask is a register, reset to all-ones, loaded from mask_wdata on mask_we.
- Undefined: mask is constant 0 and mask_we/mask_wdata are ignored.

Verification
REQ-036 stage_busy=4'b0100, ld_hazard=0 -> stall=4'b0111, flush=4'b1000.
REQ-037 ld_hazard=1, stage_busy=0 -> stall=4'b0011, flush=4'b0100; with stage_busy[3]=1 added -> stall=4'b1111, flush=0.
REQ-038 commit_en=1, commit_pc=0x40, commit_exp=3, irq=1, ie=1 -> next cycle: redirect=1, new_pc=0x100, epc=0x40, exp_code=3, flush=4'b1111; the cycle after: redirect=0, int_detect=0 (ie=0).
REQ-039 ie=1, mask=0, irq=8'h01, commit_en=1, commit_pc=0x3FFFFFFF -> epc=0x0 (wrap), new_pc=0x100, exp_code=0.
REQ-040 Commit exception held with stage_busy[3]=1 for 3 cycles -> no redirect until the busy drops; then a single one-cycle redirect.
REQ-041 ERET with epc=0x80 -> redirect=1, new_pc=0x80, exe_mode and ie restored; rst pulsed during that REDIR cycle -> redirect=0, epc=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake/status bundle between the pipeline datapath and pipe_ctrl.
// master = pipeline side (drives requests), slave = pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int NUM_STAGES = 4,
  parameter int ADDR_W     = 30,
  parameter int IRQ_W      = 8,
  parameter int EXP_W      = 3
);
  logic [NUM_STAGES-1:0] stage_busy;
  logic                  ld_hazard;
  logic [IRQ_W-1:0]      irq;
  logic                  commit_en;
  logic [ADDR_W-1:0]     commit_pc;
  logic [EXP_W-1:0]      commit_exp;
  logic                  commit_eret;
  logic                  ie_we;
  logic                  ie_wdata;
  logic                  mask_we;
  logic [IRQ_W-1:0]      mask_wdata;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] flush;
  logic                  redirect;
  logic [ADDR_W-1:0]     new_pc;
  logic [ADDR_W-1:0]     epc;
  logic [EXP_W-1:0]      exp_code;
  logic                  exe_mode;
  logic                  ie;
  logic [IRQ_W-1:0]      mask;
  logic                  int_detect;

  modport master (
    output stage_busy, ld_hazard, irq, commit_en, commit_pc, commit_exp, commit_eret,
           ie_we, ie_wdata, mask_we, mask_wdata,
    input  stall, flush, redirect, new_pc, epc, exp_code, exe_mode, ie, mask, int_detect
  );

  modport slave (
    input  stage_busy, ld_hazard, irq, commit_en, commit_pc, commit_exp, commit_eret,
           ie_we, ie_wdata, mask_we, mask_wdata,
    output stall, flush, redirect, new_pc, epc, exp_code, exe_mode, ie, mask, int_detect
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush generation plus exception/interrupt/ERET redirect control.
// Optional PIPE_CTRL_IRQ_MASK_EN adds a writable interrupt mask register.
module pipe_ctrl #(
  parameter int          NUM_STAGES = 4,
  parameter int          ADDR_W     = 30,
  parameter int          IRQ_W      = 8,
  parameter int          EXP_W      = 3,
  parameter int          HAZ_STAGE  = 1,
  parameter int unsigned EXC_VEC    = 32'h100
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, REDIR = 1'b1} state_t;

  state_t                state;
  state_t                next_state;
  logic [NUM_STAGES-1:0] stall_run;
  logic [NUM_STAGES-1:0] flush_run;
  logic                  busy_acc;
  logic [IRQ_W-1:0]      mask;
  logic                  int_detect;
  logic                  commit_ok;
  logic                  take_exc;
  logic                  take_int;
  logic                  take_eret;
  logic                  take_any;
  logic [ADDR_W-1:0]     target;
  logic                  redirect;
  logic [ADDR_W-1:0]     new_pc;
  logic [ADDR_W-1:0]     epc;
  logic [EXP_W-1:0]      exp_code;
  logic                  exe_mode;
  logic                  ie;
  logic                  saved_mode;
  logic                  saved_ie;

`ifdef PIPE_CTRL_IRQ_MASK_EN
  // Writable interrupt mask, all lines masked out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask <= '1;
    end else if (bus.mask_we) begin
      mask <= bus.mask_wdata;
    end else begin
      mask <= mask;
    end
  end
`else
  logic unused_mask_wr;
  assign mask           = '0;
  assign unused_mask_wr = ^{bus.mask_we, bus.mask_wdata};
`endif

  // A busy stage holds every stage above it; the hazard holds HAZ_STAGE and above
  always_comb begin
    busy_acc  = 1'b0;
    stall_run = '0;
    flush_run = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      busy_acc     = busy_acc | bus.stage_busy[i];
      stall_run[i] = busy_acc | (bus.ld_hazard & (i <= HAZ_STAGE));
    end
    for (int i = 0; i < NUM_STAGES - 1; i++) begin
      flush_run[i+1] = stall_run[i] & ~stall_run[i+1];
    end
  end

  assign int_detect = bus.ie & (|(bus.irq & ~mask)) & (state == RUN);
  assign commit_ok  = (state == RUN) & bus.commit_en & ~stall_run[NUM_STAGES-1];
  assign take_exc   = commit_ok & (bus.commit_exp != '0);
  assign take_int   = commit_ok & ~take_exc & int_detect;
  assign take_eret  = commit_ok & ~take_exc & ~int_detect & bus.commit_eret;
  assign take_any   = take_exc | take_int | take_eret;

  // Next-state and redirect target selection
  always_comb begin
    next_state = RUN;
    target     = epc;
    case (state)
      RUN: begin
        if (take_any) begin
          next_state = REDIR;
        end else begin
          next_state = RUN;
        end
      end
      REDIR:   next_state = RUN;
      default: next_state = RUN;
    endcase
    if (take_exc || take_int) begin
      target = ADDR_W'(EXC_VEC);
    end else begin
      target = epc;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Architectural control state and redirect outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect   <= 1'b0;
      new_pc     <= '0;
      epc        <= '0;
      exp_code   <= '0;
      exe_mode   <= 1'b0;
      ie         <= 1'b0;
      saved_mode <= 1'b0;
      saved_ie   <= 1'b0;
    end else begin
      redirect <= take_any;
      if (take_any) begin
        new_pc <= target;
      end
      if (take_exc || take_int) begin
        epc        <= take_exc ? bus.commit_pc : bus.commit_pc + ADDR_W'(1);
        exp_code   <= take_exc ? bus.commit_exp : '0;
        saved_mode <= exe_mode;
        saved_ie   <= ie;
        exe_mode   <= 1'b0;
        ie         <= 1'b0;
      end else if (take_eret) begin
        exe_mode <= saved_mode;
        ie       <= saved_ie;
      end else if (bus.ie_we) begin
        ie <= bus.ie_wdata;
      end
    end
  end

  assign bus.stall      = (state == REDIR) ? '0 : stall_run;
  assign bus.flush      = (state == REDIR) ? '1 : flush_run;
  assign bus.redirect   = redirect;
  assign bus.new_pc     = new_pc;
  assign bus.epc        = epc;
  assign bus.exp_code   = exp_code;
  assign bus.exe_mode   = exe_mode;
  assign bus.ie         = ie;
  assign bus.mask       = mask;
  assign bus.int_detect = int_detect;

endmodule
